// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch-stage state encoding and the sequential PC step.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam word_t PC_STEP_W = 32'd4;

endpackage

// File: rtl/pipeline_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues icache reads and drives the fetch/decode latch
// controls, absorbing redirects (immediate or deferred until the outstanding read returns), stalls and halt.
module pipeline_fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000,
  parameter word_t PC_STEP = PC_STEP_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        halt_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pcplus4_o,
  output logic [3:0]  addr_top_four_o,
  output logic        pcpause_o,
  output logic        nopmode_o
);

  fetch_state_t state, state_nxt;
  word_t        pc, pc_nxt;
  word_t        pend_addr, pend_addr_nxt;
  logic         pend, pend_nxt;
  logic         fire;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == FETCH && halt_i) begin
      state_nxt = HALTED;
    end
  end

  always_comb begin
    imemREN         = (state == FETCH);
    imemaddr        = pc;
    instruction_o   = iload;
    pcplus4_o       = pc + PC_STEP;
    addr_top_four_o = pc[31:28];
    nopmode_o       = (state == HALTED) || redirect_i || pend || (!fire && !stall_i);
    pcpause_o       = stall_i && !nopmode_o;
  end

  assign fire = ihit && imemREN;

  // Next-PC selection; a redirect that arrives while a read is outstanding is parked
  // in pend/pend_addr so imemaddr never moves before the icache answers.
  always_comb begin
    pc_nxt        = pc;
    pend_nxt      = pend;
    pend_addr_nxt = pend_addr;
    if (state == HALTED || halt_i) begin
      pend_nxt = 1'b0;
    end else if (redirect_i && fire) begin
      pc_nxt   = redirect_addr_i;
      pend_nxt = 1'b0;
    end else if (redirect_i) begin
      pend_nxt      = 1'b1;
      pend_addr_nxt = redirect_addr_i;
    end else if (pend && fire) begin
      pc_nxt   = pend_addr;
      pend_nxt = 1'b0;
    end else if (fire && !stall_i) begin
      pc_nxt = pc + PC_STEP;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc        <= PC_INIT;
      pend      <= 1'b0;
      pend_addr <= '0;
    end else begin
      pc        <= pc_nxt;
      pend      <= pend_nxt;
      pend_addr <= pend_addr_nxt;
    end
  end

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Self-checking bench for pipeline_fetch_unit: directed scenarios plus a randomized run
// checked against a behavioural model of the fetch rules.
module tb_pipeline_fetch_unit;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] iload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        halt_i;
  logic [31:0] instruction_o;
  logic [31:0] pcplus4_o;
  logic [3:0]  addr_top_four_o;
  logic        pcpause_o;
  logic        nopmode_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: architectural PC, at most one deferred redirect target, halted flag
  logic [31:0] m_pc;
  logic [31:0] m_redir_q[$];
  bit          m_halted;

  pipeline_fetch_unit #(.PC_INIT(32'h0), .PC_STEP(32'd4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .halt_i(halt_i), .instruction_o(instruction_o), .pcplus4_o(pcplus4_o),
    .addr_top_four_o(addr_top_four_o), .pcpause_o(pcpause_o), .nopmode_o(nopmode_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic bit exp_ren();
    return !m_halted;
  endfunction

  function automatic bit exp_nop();
    bit f;
    f = ihit && !m_halted;
    return m_halted || redirect_i || (m_redir_q.size() != 0) || (!f && !stall_i);
  endfunction

  function automatic bit exp_pause();
    return stall_i && !exp_nop();
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    m_redir_q.delete();
    m_halted = 0;
  endtask

  task automatic model_update();
    bit f;
    f = ihit && !m_halted;
    if (m_halted || halt_i) begin
      m_halted = 1;
      m_redir_q.delete();
    end else if (redirect_i) begin
      m_redir_q.delete();
      if (f) m_pc = redirect_addr_i;
      else   m_redir_q.push_back(redirect_addr_i);
    end else if (m_redir_q.size() != 0 && f) begin
      m_pc = m_redir_q.pop_front();
    end else if (f && !stall_i) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!nRST) model_reset();
    else       model_update();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    ihit = 0; stall_i = 0; redirect_i = 0; redirect_addr_i = 0; halt_i = 0; iload = 0;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    idle_inputs();
    ihit = 1; redirect_i = 1; redirect_addr_i = a;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    nRST = 0;
    idle_inputs();
    model_reset();
    repeat (2) tick();
    #1;
    n_tests++; if (imemaddr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want %h", imemaddr, 32'h0); end
    n_tests++; if (imemREN !== 1'b1) begin n_fail++; $display("FAIL reset_ren got %b want 1", imemREN); end
    n_tests++; if (nopmode_o !== 1'b1) begin n_fail++; $display("FAIL reset_nop got %b want 1", nopmode_o); end
    n_tests++; if (pcpause_o !== 1'b0) begin n_fail++; $display("FAIL reset_pause got %b want 0", pcpause_o); end
    nRST = 1;
    ihit = 1; iload = 32'h2401000A;
    #1;
    n_tests++; if (instruction_o !== 32'h2401000A) begin n_fail++; $display("FAIL first_instr got %h want 2401000a", instruction_o); end
    n_tests++; if (pcplus4_o !== 32'h4) begin n_fail++; $display("FAIL first_pc4 got %h want 4", pcplus4_o); end
    n_tests++; if (nopmode_o !== 1'b0) begin n_fail++; $display("FAIL first_nop got %b want 0", nopmode_o); end
    tick();
    #1;
    n_tests++; if (imemaddr !== 32'h4) begin n_fail++; $display("FAIL first_next got %h want 4", imemaddr); end
  endtask

  task automatic test_sequential();
    goto_pc(32'h0);
    ihit = 1;
    for (int i = 0; i < 4; i++) begin
      iload = $urandom;
      #1;
      n_tests++; if (imemaddr !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_addr[%0d] got %h want %h", i, imemaddr, 32'(i * 4)); end
      tick();
    end
    goto_pc(32'hFFFF_FFFC);
    #1;
    n_tests++; if (pcplus4_o !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got %h want 0", pcplus4_o); end
    n_tests++; if (addr_top_four_o !== 4'hF) begin n_fail++; $display("FAIL wrap_top got %h want f", addr_top_four_o); end
  endtask

  task automatic test_stall();
    goto_pc(32'h8);
    ihit = 1; stall_i = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++; if (pcpause_o !== 1'b1) begin n_fail++; $display("FAIL stall_pause[%0d] got %b want 1", i, pcpause_o); end
      n_tests++; if (nopmode_o !== 1'b0) begin n_fail++; $display("FAIL stall_nop[%0d] got %b want 0", i, nopmode_o); end
      n_tests++; if (imemaddr !== 32'h8) begin n_fail++; $display("FAIL stall_addr[%0d] got %h want 8", i, imemaddr); end
      tick();
    end
    stall_i = 0;
    tick();
    #1;
    n_tests++; if (imemaddr !== 32'hC) begin n_fail++; $display("FAIL stall_release got %h want c", imemaddr); end
  endtask

  task automatic test_redirect_stall();
    goto_pc(32'h10);
    ihit = 1; redirect_i = 1; redirect_addr_i = 32'h40; stall_i = 1;
    #1;
    n_tests++; if (nopmode_o !== 1'b1) begin n_fail++; $display("FAIL rs_nop got %b want 1", nopmode_o); end
    n_tests++; if (pcpause_o !== 1'b0) begin n_fail++; $display("FAIL rs_pause got %b want 0", pcpause_o); end
    tick();
    idle_inputs();
    #1;
    n_tests++; if (imemaddr !== 32'h40) begin n_fail++; $display("FAIL rs_target got %h want 40", imemaddr); end
  endtask

  task automatic test_pending_redirect();
    for (int v = 0; v < 2; v++) begin
      goto_pc(32'h20);
      redirect_i = 1; redirect_addr_i = 32'h80;
      tick();
      if (v == 1) begin
        redirect_addr_i = 32'hC0;
        tick();
      end
      redirect_i = 0;
      tick();
      #1;
      n_tests++; if (imemaddr !== 32'h20) begin n_fail++; $display("FAIL pend_hold[%0d] got %h want 20", v, imemaddr); end
      ihit = 1;
      #1;
      n_tests++; if (nopmode_o !== 1'b1) begin n_fail++; $display("FAIL pend_nop[%0d] got %b want 1", v, nopmode_o); end
      tick();
      ihit = 0;
      #1;
      n_tests++; if (imemaddr !== (v == 0 ? 32'h80 : 32'hC0)) begin n_fail++; $display("FAIL pend_target[%0d] got %h want %h", v, imemaddr, (v == 0 ? 32'h80 : 32'hC0)); end
    end
  endtask

  task automatic test_halt();
    goto_pc(32'h30);
    ihit = 1; halt_i = 1; redirect_i = 1; redirect_addr_i = 32'h100;
    tick();
    halt_i = 0; redirect_i = 0;
    #1;
    n_tests++; if (imemREN !== 1'b0) begin n_fail++; $display("FAIL halt_ren got %b want 0", imemREN); end
    n_tests++; if (nopmode_o !== 1'b1) begin n_fail++; $display("FAIL halt_nop got %b want 1", nopmode_o); end
    n_tests++; if (imemaddr !== 32'h30) begin n_fail++; $display("FAIL halt_pc got %h want 30", imemaddr); end
    redirect_i = 1; redirect_addr_i = 32'h200; stall_i = 1;
    tick();
    redirect_i = 0; stall_i = 0;
    tick();
    #1;
    n_tests++; if (imemaddr !== 32'h30) begin n_fail++; $display("FAIL halt_sticky got %h want 30", imemaddr); end
    n_tests++; if (pcpause_o !== 1'b0) begin n_fail++; $display("FAIL halt_pause got %b want 0", pcpause_o); end
    nRST = 0;
    #1;
    n_tests++; if (imemaddr !== 32'h0) begin n_fail++; $display("FAIL halt_rst_addr got %h want 0", imemaddr); end
    n_tests++; if (imemREN !== 1'b1) begin n_fail++; $display("FAIL halt_rst_ren got %b want 1", imemREN); end
    tick();
    nRST = 1;
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      ihit            = ($urandom_range(0, 9) < 7);
      stall_i         = ($urandom_range(0, 9) < 2);
      redirect_i      = ($urandom_range(0, 19) < 3);
      redirect_addr_i = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      halt_i          = ($urandom_range(0, 99) == 0);
      iload           = $urandom;
      if (m_halted && $urandom_range(0, 3) == 0) begin
        nRST = 0;
        #1;
        model_reset();
      end
      #1;
      n_tests++; if (imemaddr !== m_pc) begin n_fail++; $display("FAIL rnd_addr c=%0d got %h want %h", c, imemaddr, m_pc); end
      n_tests++; if (imemREN !== exp_ren()) begin n_fail++; $display("FAIL rnd_ren c=%0d got %b want %b", c, imemREN, exp_ren()); end
      n_tests++; if (instruction_o !== iload) begin n_fail++; $display("FAIL rnd_instr c=%0d got %h want %h", c, instruction_o, iload); end
      n_tests++; if (pcplus4_o !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_pc4 c=%0d got %h want %h", c, pcplus4_o, m_pc + 32'd4); end
      n_tests++; if (addr_top_four_o !== m_pc[31:28]) begin n_fail++; $display("FAIL rnd_top c=%0d got %h want %h", c, addr_top_four_o, m_pc[31:28]); end
      n_tests++; if (nopmode_o !== exp_nop()) begin n_fail++; $display("FAIL rnd_nop c=%0d got %b want %b", c, nopmode_o, exp_nop()); end
      n_tests++; if (pcpause_o !== exp_pause()) begin n_fail++; $display("FAIL rnd_pause c=%0d got %b want %b", c, pcpause_o, exp_pause()); end
      tick();
      nRST = 1;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_pending_redirect();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
